// File: rtl/experiar_memory_pkg.sv
// Shared types and constants for the ExperiarCore tile memory arbiters.
package experiar_memory_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'b00,
    STATE_ACCESS  = 2'b01,
    STATE_RESPOND = 2'b10
  } state_t;

  localparam logic MASTER_CORE    = 1'b0;
  localparam logic MASTER_MANAGER = 1'b1;

  // One-hot mask selecting a single master, used to exclude the master just served.
  function automatic logic [1:0] masterMask(input logic index);
    return index ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational two-way round-robin picker; masked requesters are never granted.
module memory_arbiter_select
  import experiar_memory_pkg::*;
(
  input  logic       request0,
  input  logic       request1,
  input  logic       lastGrant,
  input  logic [1:0] excludeMask,
  output logic       valid,
  output logic       grantIndex
);

  logic [1:0] eligible_s;

  assign eligible_s = {request1, request0} & ~excludeMask;

  // Pick the single eligible master, or on a tie the one not granted last.
  always_comb begin
    valid      = 1'b0;
    grantIndex = MASTER_CORE;
    case (eligible_s)
      2'b01: begin
        valid      = 1'b1;
        grantIndex = MASTER_CORE;
      end
      2'b10: begin
        valid      = 1'b1;
        grantIndex = MASTER_MANAGER;
      end
      2'b11: begin
        valid      = 1'b1;
        grantIndex = ~lastGrant;
      end
      default: begin
        valid      = 1'b0;
        grantIndex = MASTER_CORE;
      end
    endcase
  end

endmodule

// File: rtl/core_memory_arbiter.sv
// Shares one single-port SRAM between the core and the management bridge using
// a fixed IDLE/ACCESS/RESPOND sequence with round-robin arbitration.
module core_memory_arbiter
  import experiar_memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 24,
  parameter int SRAM_ADDRESS_WIDTH = 9
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          core_request,
  input  logic                          core_writeEnable,
  input  logic [3:0]                    core_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0]      core_address,
  input  logic [31:0]                   core_writeData,
  output logic [31:0]                   core_readData,
  output logic                          core_ready,
  input  logic                          manager_request,
  input  logic                          manager_writeEnable,
  input  logic [3:0]                    manager_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0]      manager_address,
  input  logic [31:0]                   manager_writeData,
  output logic [31:0]                   manager_readData,
  output logic                          manager_ready,
  output logic                          sram_csb,
  output logic                          sram_web,
  output logic [3:0]                    sram_wmask,
  output logic [SRAM_ADDRESS_WIDTH-1:0] sram_addr,
  output logic [31:0]                   sram_din,
  input  logic [31:0]                   sram_dout
);

  state_t                     state_r, nextState_s;
  logic                       grant_r, lastGrant_r;
  logic [ADDRESS_WIDTH-3:0]   latchedAddress_r;
  logic                       latchedWriteEnable_r;
  logic [3:0]                 latchedByteSelect_r;
  logic [31:0]                latchedWriteData_r;
  logic [1:0]                 exclude_s;
  logic                       selValid_s, selIndex_s;
  logic                       inRange_s, active_s;
  logic [31:0]                respData_s;
  logic                       unusedAddressBits_s;

  assign unusedAddressBits_s = ^{core_address[1:0], manager_address[1:0]};

  // In RESPOND the master just served still holds request high, so mask it out.
  always_comb begin
    case (state_r)
      STATE_IDLE:    exclude_s = 2'b00;
      STATE_RESPOND: exclude_s = masterMask(grant_r);
      default:       exclude_s = 2'b11;
    endcase
  end

  memory_arbiter_select select (
    .request0   (core_request),
    .request1   (manager_request),
    .lastGrant  (lastGrant_r),
    .excludeMask(exclude_s),
    .valid      (selValid_s),
    .grantIndex (selIndex_s)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_r <= STATE_IDLE;
    else       state_r <= nextState_s;
  end

  // Next-state logic.
  always_comb begin
    case (state_r)
      STATE_IDLE:    nextState_s = selValid_s ? STATE_ACCESS : STATE_IDLE;
      STATE_ACCESS:  nextState_s = STATE_RESPOND;
      STATE_RESPOND: nextState_s = selValid_s ? STATE_ACCESS : STATE_IDLE;
      default:       nextState_s = STATE_IDLE;
    endcase
  end

  // Grant bookkeeping and capture of the selected master's request.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant_r              <= MASTER_CORE;
      lastGrant_r          <= MASTER_MANAGER;
      latchedAddress_r     <= '0;
      latchedWriteEnable_r <= 1'b0;
      latchedByteSelect_r  <= 4'b0000;
      latchedWriteData_r   <= 32'h0000_0000;
    end else begin
      if (selValid_s) begin
        grant_r              <= selIndex_s;
        latchedAddress_r     <= selIndex_s ? manager_address[ADDRESS_WIDTH-1:2] : core_address[ADDRESS_WIDTH-1:2];
        latchedWriteEnable_r <= selIndex_s ? manager_writeEnable : core_writeEnable;
        latchedByteSelect_r  <= selIndex_s ? manager_byteSelect : core_byteSelect;
        latchedWriteData_r   <= selIndex_s ? manager_writeData : core_writeData;
      end
      if (state_r == STATE_ACCESS) lastGrant_r <= grant_r;
    end
  end

  assign inRange_s  = ~|latchedAddress_r[ADDRESS_WIDTH-3:SRAM_ADDRESS_WIDTH];
  assign active_s   = inRange_s & (|latchedByteSelect_r);
  assign respData_s = (!latchedWriteEnable_r && active_s) ? sram_dout : 32'h0000_0000;

  // Output decode; the SRAM is only driven during ACCESS, readiness only in RESPOND.
  always_comb begin
    sram_csb         = 1'b1;
    sram_web         = 1'b1;
    sram_wmask       = 4'b0000;
    sram_addr        = '0;
    sram_din         = 32'h0000_0000;
    core_ready       = 1'b0;
    core_readData    = 32'h0000_0000;
    manager_ready    = 1'b0;
    manager_readData = 32'h0000_0000;
    case (state_r)
      STATE_ACCESS: begin
        sram_csb   = ~active_s;
        sram_web   = ~latchedWriteEnable_r;
        sram_wmask = latchedWriteEnable_r ? latchedByteSelect_r : 4'b0000;
        sram_addr  = latchedAddress_r[SRAM_ADDRESS_WIDTH-1:0];
        sram_din   = latchedWriteData_r;
      end
      STATE_RESPOND: begin
        if (grant_r == MASTER_MANAGER) begin
          manager_ready    = 1'b1;
          manager_readData = respData_s;
        end else begin
          core_ready    = 1'b1;
          core_readData = respData_s;
        end
      end
      default: begin
        sram_csb = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed and randomized bench for core_memory_arbiter with an SRAM macro model
// and a word-level memory reference.
module tb_core_memory_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        core_request, core_writeEnable, manager_request, manager_writeEnable;
  logic [3:0]  core_byteSelect, manager_byteSelect;
  logic [23:0] core_address, manager_address;
  logic [31:0] core_writeData, manager_writeData, core_readData, manager_readData;
  logic        core_ready, manager_ready;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  logic        loadMem;
  logic [31:0] sramMem [512];
  logic [31:0] expMem  [512];
  logic        lastServed;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  core_memory_arbiter dut (
    .clk(clk), .nrst(nrst),
    .core_request(core_request), .core_writeEnable(core_writeEnable),
    .core_byteSelect(core_byteSelect), .core_address(core_address),
    .core_writeData(core_writeData), .core_readData(core_readData), .core_ready(core_ready),
    .manager_request(manager_request), .manager_writeEnable(manager_writeEnable),
    .manager_byteSelect(manager_byteSelect), .manager_address(manager_address),
    .manager_writeData(manager_writeData), .manager_readData(manager_readData),
    .manager_ready(manager_ready),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  function automatic logic [31:0] seedWord(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0203);
  endfunction

  // SRAM macro: samples on the rising edge, read data appears the following cycle.
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 512; i++) sramMem[i] <= seedWord(i);
    end else if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sramMem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sramMem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic isActive(input logic [3:0] bs, input logic [23:0] addr);
    return (addr[23:11] == 13'd0) && (bs != 4'b0000);
  endfunction

  task automatic setMaster(input logic m, input logic req, input logic we, input logic [3:0] bs,
                           input logic [23:0] addr, input logic [31:0] wd);
    if (m) begin
      manager_request = req; manager_writeEnable = we; manager_byteSelect = bs;
      manager_address = addr; manager_writeData = wd;
    end else begin
      core_request = req; core_writeEnable = we; core_byteSelect = bs;
      core_address = addr; core_writeData = wd;
    end
  endtask

  task automatic accessChecks(input string tag, input logic we, input logic [3:0] bs,
                              input logic [23:0] addr, input logic [31:0] wd);
    logic act;
    act = isActive(bs, addr);
    check({tag, ".csb"}, sram_csb, !act);
    check({tag, ".coreRdyAcc"}, core_ready, 1'b0);
    check({tag, ".mgrRdyAcc"}, manager_ready, 1'b0);
    if (act) begin
      check({tag, ".addr"}, sram_addr, addr[10:2]);
      check({tag, ".web"}, sram_web, !we);
      check({tag, ".wmask"}, sram_wmask, we ? bs : 4'b0000);
      if (we) check({tag, ".din"}, sram_din, wd);
    end
  endtask

  task automatic respondChecks(input string tag, input logic m, input logic we, input logic [3:0] bs,
                               input logic [23:0] addr, input logic [31:0] wd);
    logic        act;
    logic [8:0]  idx;
    logic [31:0] expData;
    act = isActive(bs, addr);
    idx = addr[10:2];
    expData = (!we && act) ? expMem[idx] : 32'h0000_0000;
    check({tag, ".coreRdy"}, core_ready, !m);
    check({tag, ".mgrRdy"}, manager_ready, m);
    check({tag, ".data"}, m ? manager_readData : core_readData, expData);
    check({tag, ".idleData"}, m ? core_readData : manager_readData, 32'h0000_0000);
    check({tag, ".csbResp"}, sram_csb, 1'b1);
    if (we && act)
      for (int b = 0; b < 4; b++)
        if (bs[b]) expMem[idx][8*b +: 8] = wd[8*b +: 8];
    lastServed = m;
  endtask

  // One transaction from an idle arbiter: request, ACCESS, RESPOND, back to IDLE.
  task automatic single(input string tag, input logic m, input logic we, input logic [3:0] bs,
                        input logic [23:0] addr, input logic [31:0] wd);
    setMaster(m, 1'b1, we, bs, addr, wd);
    @(negedge clk);
    accessChecks(tag, we, bs, addr, wd);
    @(negedge clk);
    respondChecks(tag, m, we, bs, addr, wd);
    setMaster(m, 1'b0, we, bs, addr, wd);
    @(negedge clk);
    check({tag, ".coreRdyAfter"}, core_ready, 1'b0);
    check({tag, ".mgrRdyAfter"}, manager_ready, 1'b0);
  endtask

  // Both masters request in the same cycle; the one not served most recently goes first.
  task automatic pair(input string tag,
                      input logic weC, input logic [3:0] bsC, input logic [23:0] adC, input logic [31:0] wdC,
                      input logic weM, input logic [3:0] bsM, input logic [23:0] adM, input logic [31:0] wdM);
    logic first;
    first = !lastServed;
    setMaster(1'b0, 1'b1, weC, bsC, adC, wdC);
    setMaster(1'b1, 1'b1, weM, bsM, adM, wdM);
    @(negedge clk);
    if (first) accessChecks({tag, ".1st"}, weM, bsM, adM, wdM);
    else       accessChecks({tag, ".1st"}, weC, bsC, adC, wdC);
    @(negedge clk);
    if (first) respondChecks({tag, ".1st"}, 1'b1, weM, bsM, adM, wdM);
    else       respondChecks({tag, ".1st"}, 1'b0, weC, bsC, adC, wdC);
    setMaster(first, 1'b0, 1'b0, 4'b0000, 24'h0, 32'h0);
    @(negedge clk);
    if (first) accessChecks({tag, ".2nd"}, weC, bsC, adC, wdC);
    else       accessChecks({tag, ".2nd"}, weM, bsM, adM, wdM);
    @(negedge clk);
    if (first) respondChecks({tag, ".2nd"}, 1'b0, weC, bsC, adC, wdC);
    else       respondChecks({tag, ".2nd"}, 1'b1, weM, bsM, adM, wdM);
    setMaster(!first, 1'b0, 1'b0, 4'b0000, 24'h0, 32'h0);
    @(negedge clk);
    check({tag, ".coreRdyAfter"}, core_ready, 1'b0);
    check({tag, ".mgrRdyAfter"}, manager_ready, 1'b0);
  endtask

  function automatic logic [23:0] randAddr();
    logic [23:0] a;
    a = {11'd0, 9'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
    if ($urandom_range(0, 7) == 0) a[$urandom_range(11, 23)] = 1'b1;
    return a;
  endfunction

  initial begin
    nrst = 1'b0;
    loadMem = 1'b1;
    lastServed = 1'b1;
    setMaster(1'b0, 1'b0, 1'b0, 4'b0000, 24'h0, 32'h0);
    setMaster(1'b1, 1'b0, 1'b0, 4'b0000, 24'h0, 32'h0);
    for (int i = 0; i < 512; i++) expMem[i] = seedWord(i);
    repeat (2) @(negedge clk);

    check("rst.csb", sram_csb, 1'b1);
    check("rst.web", sram_web, 1'b1);
    check("rst.wmask", sram_wmask, 4'b0000);
    check("rst.addr", sram_addr, 9'd0);
    check("rst.din", sram_din, 32'h0);
    check("rst.coreRdy", core_ready, 1'b0);
    check("rst.mgrRdy", manager_ready, 1'b0);
    check("rst.coreData", core_readData, 32'h0);
    check("rst.mgrData", manager_readData, 32'h0);
    loadMem = 1'b0;
    nrst = 1'b1;
    @(negedge clk);

    // Tie right after reset: core first, manager immediately after; then reversal.
    pair("tie0", 1'b0, 4'hF, 24'h000004, 32'h0, 1'b0, 4'hF, 24'h000008, 32'h0);
    single("coreOnly", 1'b0, 1'b0, 4'hF, 24'h00000C, 32'h0);
    pair("tie1", 1'b0, 4'hF, 24'h000014, 32'h0, 1'b0, 4'hF, 24'h000018, 32'h0);

    single("wrBeef", 1'b0, 1'b1, 4'hF, 24'h000010, 32'hDEAD_BEEF);
    single("rdBeef", 1'b0, 1'b0, 4'hF, 24'h000010, 32'h0);
    check("beefValue", expMem[4], 32'hDEAD_BEEF);

    single("wrFull", 1'b0, 1'b1, 4'hF, 24'h000020, 32'h1122_3344);
    single("wrByte", 1'b0, 1'b1, 4'b0010, 24'h000020, 32'hAAAA_AAAA);
    single("rdMerge", 1'b0, 1'b0, 4'hF, 24'h000020, 32'h0);
    check("mergeValue", expMem[8], 32'h1122_AA44);

    single("oorRd", 1'b1, 1'b0, 4'hF, 24'h000800, 32'h0);
    single("oorWr", 1'b1, 1'b1, 4'hF, 24'h000800, 32'hFFFF_FFFF);
    single("alias0", 1'b1, 1'b0, 4'hF, 24'h000000, 32'h0);

    single("bs0Wr", 1'b0, 1'b1, 4'b0000, 24'h000010, 32'h5555_5555);
    single("bs0Chk", 1'b0, 1'b0, 4'hF, 24'h000010, 32'h0);

    // Reset asserted in the middle of ACCESS for a core write.
    setMaster(1'b0, 1'b1, 1'b1, 4'hF, 24'h000040, 32'h1234_5678);
    @(negedge clk);
    accessChecks("abort", 1'b1, 4'hF, 24'h000040, 32'h1234_5678);
    #2 nrst = 1'b0;
    setMaster(1'b0, 1'b0, 1'b0, 4'b0000, 24'h0, 32'h0);
    #1;
    check("abort.csb", sram_csb, 1'b1);
    check("abort.web", sram_web, 1'b1);
    check("abort.addr", sram_addr, 9'd0);
    check("abort.coreRdy", core_ready, 1'b0);
    @(negedge clk);
    check("abort.noRdy", core_ready, 1'b0);
    nrst = 1'b1;
    lastServed = 1'b1;
    @(negedge clk);
    single("afterAbort", 1'b0, 1'b0, 4'hF, 24'h000040, 32'h0);
    check("abortWordKept", expMem[16], seedWord(16));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        pair("rndPair", 1'($urandom), 4'($urandom), randAddr(), $urandom,
                        1'($urandom), 4'($urandom), randAddr(), $urandom);
      else
        single("rndOne", 1'($urandom), 1'($urandom), 4'($urandom), randAddr(), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
